// File: rtl/band_mixer.sv
// Three-band recombiner: one shared multiplier, stepped over low/mid/high by a small FSM,
// sums into a wide accumulator, then floors, saturates and strobes the mixed sample.
module band_mixer #(
  parameter int WIDTH     = 22,
  parameter int PRESICION = 14
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_ykbajos,
  input  logic [WIDTH-1:0] i_ykmedios,
  input  logic [WIDTH-1:0] i_ykaltos,
  input  logic             i_gain_wr,
  input  logic [1:0]       i_gain_sel,
  input  logic [WIDTH-1:0] i_gain_data,
  output logic [WIDTH-1:0] o_yk,
  output logic             o_yk_valid,
  output logic             o_busy,
  output logic             o_clip,
  output logic             o_overrun
);

  localparam int MAGNITUD = WIDTH - PRESICION - 1;
  localparam int PW       = 2 * WIDTH;
  localparam int AW       = 2 * WIDTH + 2;
  localparam logic [WIDTH-1:0] UNITY   = WIDTH'(1) << PRESICION;
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAC0 = 3'd1,
    MAC1 = 3'd2,
    MAC2 = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                  r_state;
  logic [WIDTH-1:0]        r_gain0, r_gain1, r_gain2;
  logic [WIDTH-1:0]        r_s0, r_s1, r_s2;
  logic [WIDTH-1:0]        r_g0, r_g1, r_g2;
  logic signed [AW-1:0]    r_acc;
  logic [WIDTH-1:0]        r_yk;
  logic                    r_yk_valid;
  logic                    r_busy;
  logic                    r_clip;
  logic                    r_overrun;

  logic signed [WIDTH-1:0] w_mul_a, w_mul_b;
  logic signed [PW-1:0]    w_prod;
  logic signed [AW-1:0]    w_res;
  logic [AW-MAGNITUD-PRESICION-1:0] w_top;
  logic                    w_in_range;

  always_comb begin
    w_mul_a = r_s2;
    w_mul_b = r_g2;
    case (r_state)
      MAC0: begin
        w_mul_a = r_s0;
        w_mul_b = r_g0;
      end
      MAC1: begin
        w_mul_a = r_s1;
        w_mul_b = r_g1;
      end
      default: begin
        w_mul_a = r_s2;
        w_mul_b = r_g2;
      end
    endcase
  end

  assign w_prod = w_mul_a * w_mul_b;
  assign w_res  = r_acc >>> PRESICION;

  // Result fits the sample width only if every bit above the sample's sign matches it.
  assign w_top      = w_res[AW-1:MAGNITUD+PRESICION];
  assign w_in_range = (&w_top) | ~(|w_top);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gain0 <= UNITY;
      r_gain1 <= UNITY;
      r_gain2 <= UNITY;
    end else if (i_gain_wr) begin
      case (i_gain_sel)
        2'd0:    r_gain0 <= i_gain_data;
        2'd1:    r_gain1 <= i_gain_data;
        2'd2:    r_gain2 <= i_gain_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_s0       <= '0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_g0       <= UNITY;
      r_g1       <= UNITY;
      r_g2       <= UNITY;
      r_acc      <= '0;
      r_yk       <= '0;
      r_yk_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_clip     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_yk_valid <= 1'b0;
      r_overrun  <= i_enable && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (i_enable) begin
            r_s0    <= i_ykbajos;
            r_s1    <= i_ykmedios;
            r_s2    <= i_ykaltos;
            r_g0    <= r_gain0;
            r_g1    <= r_gain1;
            r_g2    <= r_gain2;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= MAC0;
          end
        end
        MAC0: begin
          r_acc   <= r_acc + AW'(w_prod);
          r_state <= MAC1;
        end
        MAC1: begin
          r_acc   <= r_acc + AW'(w_prod);
          r_state <= MAC2;
        end
        MAC2: begin
          r_acc   <= r_acc + AW'(w_prod);
          r_state <= DONE;
        end
        DONE: begin
          if (w_in_range) begin
            r_yk   <= w_res[WIDTH-1:0];
            r_clip <= 1'b0;
          end else begin
            r_yk   <= w_res[AW-1] ? SAT_NEG : SAT_POS;
            r_clip <= 1'b1;
          end
          r_yk_valid <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_yk       = r_yk;
  assign o_yk_valid = r_yk_valid;
  assign o_busy     = r_busy;
  assign o_clip     = r_clip;
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_band_mixer.sv
// Self-checking bench for band_mixer: directed vector table, hand-written corner
// sequences, and randomized samples/gains against an integer-arithmetic model.
module tb_band_mixer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic [21:0] i_ykbajos = '0, i_ykmedios = '0, i_ykaltos = '0;
  logic        i_gain_wr = 1'b0;
  logic [1:0]  i_gain_sel = '0;
  logic [21:0] i_gain_data = '0;
  logic [21:0] o_yk;
  logic        o_yk_valid, o_busy, o_clip, o_overrun;

  int n_chk = 0;
  int n_fail = 0;
  longint m_gain [3];

  band_mixer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
    .i_ykbajos(i_ykbajos), .i_ykmedios(i_ykmedios), .i_ykaltos(i_ykaltos),
    .i_gain_wr(i_gain_wr), .i_gain_sel(i_gain_sel), .i_gain_data(i_gain_data),
    .o_yk(o_yk), .o_yk_valid(o_yk_valid), .o_busy(o_busy), .o_clip(o_clip),
    .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [21:0] g0, g1, g2;
    logic [21:0] s0, s1, s2;
    logic [21:0] exp_yk;
    logic        exp_clip;
  } vec_t;

  task automatic chk(input string nm, input longint got, input longint expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, expv);
    end
  endtask

  function automatic longint sx(input logic [21:0] v);
    longint r;
    r = longint'(v);
    if (v[21]) r = r - (longint'(1) <<< 22);
    return r;
  endfunction

  // Mixed value as real fixed-point arithmetic: sum of products, floor-divide by 2^14, clamp.
  function automatic logic [22:0] model_mix(input logic [21:0] a, b, c);
    longint sum, res;
    sum = sx(a) * m_gain[0] + sx(b) * m_gain[1] + sx(c) * m_gain[2];
    res = sum >>> 14;
    if (res > 2097151)       return {1'b1, 22'h1FFFFF};
    else if (res < -2097152) return {1'b1, 22'h200000};
    else                     return {1'b0, res[21:0]};
  endfunction

  task automatic wr_gain(input logic [1:0] sel, input logic [21:0] data);
    i_gain_wr = 1'b1; i_gain_sel = sel; i_gain_data = data;
    @(posedge i_clk); #1;
    i_gain_wr = 1'b0;
    if (sel != 2'd3) m_gain[sel] = sx(data);
  endtask

  task automatic run_sample(input logic [21:0] a, b, c,
                            input logic [21:0] exp_yk, input logic exp_clip,
                            input string nm);
    int lat;
    i_ykbajos = a; i_ykmedios = b; i_ykaltos = c; i_enable = 1'b1;
    @(posedge i_clk); #1;
    i_enable = 1'b0;
    lat = 0;
    for (int cc = 1; cc <= 10 && lat == 0; cc++) begin
      @(posedge i_clk); #1;
      if (cc == 1) chk({nm, " busy_mac0"}, longint'(o_busy), 1);
      if (o_yk_valid) lat = cc;
    end
    chk({nm, " latency"}, lat, 4);
    chk({nm, " yk"}, longint'(o_yk), longint'(exp_yk));
    chk({nm, " clip"}, longint'(o_clip), longint'(exp_clip));
    chk({nm, " busy_done"}, longint'(o_busy), 0);
    @(posedge i_clk); #1;
    chk({nm, " valid_width"}, longint'(o_yk_valid), 0);
    chk({nm, " yk_hold"}, longint'(o_yk), longint'(exp_yk));
  endtask

  task automatic run_model(input logic [21:0] a, b, c, input string nm);
    logic [22:0] e;
    e = model_mix(a, b, c);
    run_sample(a, b, c, e[21:0], e[22], nm);
  endtask

  vec_t vecs [5];

  initial begin
    logic [22:0] e_first;
    int n_ovr, n_val;
    logic [21:0] yk_seen;

    vecs[0] = '{22'h4000, 22'h4000, 22'h4000, 22'h001000, 22'h002000, 22'h000800, 22'h003800, 1'b0};
    vecs[1] = '{22'h4000, 22'h2000, 22'h4000, 22'h004000, 22'h004000, 22'h004000, 22'h00A000, 1'b0};
    vecs[2] = '{22'h4000, 22'h4000, 22'h4000, 22'h1FFFFF, 22'h1FFFFF, 22'h1FFFFF, 22'h1FFFFF, 1'b1};
    vecs[3] = '{22'h4000, 22'h4000, 22'h4000, 22'h200000, 22'h200000, 22'h200000, 22'h200000, 1'b1};
    vecs[4] = '{22'h2000, 22'h4000, 22'h4000, 22'h3FFFFF, 22'h000000, 22'h000000, 22'h3FFFFF, 1'b0};

    for (int i = 0; i < 3; i++) m_gain[i] = 16384;

    #23;
    chk("reset yk", longint'(o_yk), 0);
    chk("reset valid", longint'(o_yk_valid), 0);
    chk("reset busy", longint'(o_busy), 0);
    chk("reset clip", longint'(o_clip), 0);
    chk("reset overrun", longint'(o_overrun), 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // First vector runs on reset gains; later ones reprogram all three.
    run_sample(vecs[0].s0, vecs[0].s1, vecs[0].s2, vecs[0].exp_yk, vecs[0].exp_clip, "vec0");
    for (int i = 1; i < 5; i++) begin
      wr_gain(2'd0, vecs[i].g0);
      wr_gain(2'd1, vecs[i].g1);
      wr_gain(2'd2, vecs[i].g2);
      run_sample(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].exp_yk, vecs[i].exp_clip,
                 $sformatf("vec%0d", i));
    end

    // Select 3 must not disturb any gain.
    wr_gain(2'd3, 22'h000001);
    run_sample(vecs[4].s0, vecs[4].s1, vecs[4].s2, vecs[4].exp_yk, vecs[4].exp_clip, "sel3_ignored");
    wr_gain(2'd1, 22'h2000);
    wr_gain(2'd3, 22'h000000);
    run_sample(22'h004000, 22'h004000, 22'h004000, 22'h008000, 1'b0, "sel3_mid_half");

    // Overrun 2 cycles after accept, plus a gain write while busy.
    wr_gain(2'd0, 22'h4000);
    wr_gain(2'd1, 22'h4000);
    e_first = model_mix(22'h001111, 22'h002222, 22'h003333);
    i_ykbajos = 22'h001111; i_ykmedios = 22'h002222; i_ykaltos = 22'h003333;
    i_enable = 1'b1;
    n_ovr = 0; n_val = 0; yk_seen = '0;
    for (int c = 0; c < 10; c++) begin
      @(posedge i_clk); #1;
      if (o_overrun) n_ovr++;
      if (o_yk_valid) begin n_val++; yk_seen = o_yk; end
      if (c == 2) chk("overrun timing", longint'(o_overrun), 1);
      if (c == 0) i_enable = 1'b0;
      if (c == 1) begin
        i_enable = 1'b1; i_ykbajos = 22'h1FFFFF;
        i_gain_wr = 1'b1; i_gain_sel = 2'd0; i_gain_data = 22'h2000;
      end
      if (c == 2) begin i_enable = 1'b0; i_gain_wr = 1'b0; end
    end
    m_gain[0] = 8192;
    chk("overrun count", n_ovr, 1);
    chk("overrun valid count", n_val, 1);
    chk("overrun yk", longint'(yk_seen), longint'(e_first[21:0]));
    run_model(22'h001111, 22'h002222, 22'h003333, "gain_after_busy");

    // Reset during MAC1 with non-unity gains loaded.
    wr_gain(2'd1, 22'h1000);
    wr_gain(2'd2, 22'h3F0000);
    i_ykbajos = 22'h001234; i_ykmedios = 22'h3F0000; i_ykaltos = 22'h000777;
    i_enable = 1'b1;
    @(posedge i_clk); #1; i_enable = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    #1;
    chk("midreset busy", longint'(o_busy), 0);
    chk("midreset yk", longint'(o_yk), 0);
    chk("midreset valid", longint'(o_yk_valid), 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) m_gain[i] = 16384;
    n_val = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge i_clk); #1;
      if (o_yk_valid) n_val++;
    end
    chk("midreset no valid", n_val, 0);
    run_model(22'h001234, 22'h3F0000, 22'h000777, "gains_back_unity");

    // Randomized samples and gain writes.
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 1) == 1)
        wr_gain(2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? 22'($urandom) : 22'($urandom_range(0, 32767)));
      run_model(22'($urandom), 22'($urandom), 22'($urandom), $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/band_mixer.md
# band_mixer

Recombines the three band outputs of the crossover filter bank (low, mid, high) into one audio sample, applying a programmable fixed-point gain per band. It sits downstream of the three filter pairs and forms the synthesis end of the three-band equalizer path. A single shared multiplier is time-multiplexed over the three bands by a small FSM. The summed result is saturated to the sample width and presented with a one-cycle valid strobe.

## Interface

- Width, 22, sample and gain word width (two's complement)
- Presicion, 14, fractional bits of samples and gains
- Magnitud, Width-Presicion-1, integer bits excluding sign
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  sample strobe; one-cycle pulse per new band triple
- ykbajos  in  Width  low-band sample, signed Q(Magnitud.Presicion)
- ykmedios  in  Width  mid-band sample, signed
- ykaltos  in  Width  high-band sample, signed
- gain_wr  in  1  gain register write strobe
- gain_sel  in  2  gain select: 0 = low, 1 = mid, 2 = high, 3 = ignored
- gain_data  in  Width  gain value, signed Q(Magnitud.Presicion)
- yk  out  Width  mixed output sample, signed
- yk_valid  out  1  one-cycle pulse when yk updates
- busy  out  1  high while a sample is being processed
- clip  out  1  qualified by yk_valid; high when the result was saturated
- overrun  out  1  one-cycle pulse when enable arrives while busy

## Operation

- Reset (reset low, asynchronous): yk = 0, yk_valid = 0, busy = 0, clip = 0, overrun = 0, FSM = IDLE, accumulator = 0, all three gains = 22'h4000 (1.0).
- Gain writes: gain_wr high at a rising edge writes gain_data to the gain selected by gain_sel. gain_sel = 3 is ignored. Writes are accepted in any state.
- Snapshot on accept: in IDLE with enable high, the FSM captures the three samples and all three gains into working registers, clears the accumulator, and moves to MAC0.
  - A gain write in the same cycle as the accept does not affect that sample; it is applied from the next sample on.
  - A gain write during processing also applies from the next sample on.
- FSM: IDLE -> MAC0 -> MAC1 -> MAC2 -> DONE -> IDLE.
  - MAC0 adds low*g0 to the accumulator.
  - MAC1 adds mid*g1.
  - MAC2 adds high*g2.
  - DONE registers yk and clip, and pulses yk_valid.
- busy is high in MAC0, MAC1, MAC2 and DONE.
- Arithmetic:
  - Each product is a full 2*Width-bit signed product.
  - The accumulator is 2*Width+2 bits signed, so the sum of three products cannot overflow.
  - Result = accumulator arithmetic-shifted right by Presicion. This truncates toward negative infinity; there is no rounding.
  - Saturation: result above 2^(Width-1)-1 gives 22'h1FFFFF with clip = 1. Result below -2^(Width-1) gives 22'h200000 with clip = 1. Otherwise clip = 0.
- Overrun: enable high in any state other than IDLE drops that sample and pulses overrun in the next cycle. The computation in flight is unaffected.
- Reset asserted mid-computation aborts it immediately: no yk_valid, and all reset values apply. Gains also return to 1.0.
- yk holds its value between yk_valid pulses.

## Timing

- Accept at edge k (IDLE, enable = 1). MAC0, MAC1 and MAC2 execute at edges k+1..k+3. DONE registers outputs at edge k+4.
- yk, clip and yk_valid are valid in the cycle after edge k+4. Latency is 4 cycles from enable to yk_valid.
- Minimum enable spacing is 5 cycles. An enable coinciding with yk_valid (FSM back in IDLE) is accepted.
- busy rises the cycle after accept and falls in the same cycle yk_valid rises.
- overrun is registered and appears one cycle after the offending enable.

## Test plan

- Unity gains after reset; ykbajos = 22'h001000, ykmedios = 22'h002000, ykaltos = 22'h000800, single enable -> yk = 22'h003800, clip = 0, yk_valid exactly 4 cycles after enable, one cycle wide.
- Write gain_sel = 1, gain_data = 22'h2000 (0.5); all bands 22'h004000 -> yk = 22'h00A000. Then write gain_sel = 3 with any data -> the next result is unchanged.
- Saturation: all bands 22'h1FFFFF at unity -> yk = 22'h1FFFFF, clip = 1. All bands 22'h200000 -> yk = 22'h200000, clip = 1.
- Truncation: gain_sel = 0 set to 22'h2000; ykbajos = 22'h3FFFFF (-1 LSB), other bands 0 -> yk = 22'h3FFFFF (floor of -0.5 LSB).
- Overrun: second enable 2 cycles after the first -> overrun pulses once, only one yk_valid, yk equals the first sample's result. A gain write during busy changes only the following sample.
- Reset asserted at the MAC1 cycle -> outputs cleared immediately, no yk_valid. After release, a new sample with non-unity bands shows gains back at 1.0.
